// File: rtl/and_chain_pkg.sv
// and_chain_pkg: shared definitions for the AND-chain BIST slice.
//   state_e   - sequencer states (IDLE, APPLY, SETTLE, CHECK, DONE)
//   N_VEC     - number of exhaustive input vectors (16)
//   VEC_W     - width of the chain input vector {d,c,b,a} (4)
//   exp_taps  - golden tap values {g,f,e} for a given vector
package and_chain_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int unsigned N_VEC = 16;
    localparam int unsigned VEC_W = 4;

    // vec = {d,c,b,a}; returns {g,f,e} with e=a&b, f=e&c, g=f&d
    function automatic logic [2:0] exp_taps(input logic [VEC_W-1:0] vec);
        logic e;
        logic f;
        logic g;
        e = vec[0] & vec[1];
        f = e & vec[2];
        g = f & vec[3];
        return {g, f, e};
    endfunction

endpackage

// File: rtl/and_chain_model.sv
// and_chain_model: combinational golden model of the 4-input AND chain.
// Ports:
//   vec  in  [3:0] chain inputs {d,c,b,a}
//   taps out [2:0] expected taps {g,f,e}
module and_chain_model
    import and_chain_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic [2:0]       taps
);

    assign taps = exp_taps(vec);

endmodule

// File: rtl/and_chain_tester.sv
// and_chain_tester: BIST sequencer for the 4-input AND-chain cell.
// Walks vectors 0..15 through the chain, holds each for SETTLE_CYCLES,
// compares taps e/f/g against the golden model and counts vectors with
// any mismatch (saturating).
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   start / re-run request, honoured only in IDLE or DONE
//   vec_out    out  [3:0] {d,c,b,a} to the chain under test
//   tap_e/f/g  in   observed chain taps
//   busy       out  run in progress
//   done       out  run finished, results valid
//   pass       out  done with zero mismatches
//   err_count  out  [CNT_W-1:0] mismatching vector count
// Optional (macro FIRST_FAIL_CAPTURE_EN):
//   fail_vec   out  [3:0] vector of the first mismatch in the run
//   fail_taps  out  [2:0] observed {g,f,e} at that mismatch
//   fail_valid out  a mismatch has been captured
module and_chain_tester
    import and_chain_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [3:0]       vec_out,
    input  logic             tap_e,
    input  logic             tap_f,
    input  logic             tap_g,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic [3:0]       fail_vec,
    output logic [2:0]       fail_taps,
    output logic             fail_valid
`endif
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_VEC    = 4'(N_VEC - 1);

    state_e     state;
    logic [3:0] vec_idx;
    logic [3:0] settle_cnt;
    logic [2:0] exp_t;
    logic [2:0] obs_t;
    logic       mismatch;

    and_chain_model u_model (
        .vec  (vec_idx),
        .taps (exp_t)
    );

    // vec_idx is loaded on entry to APPLY, so the chain sees the vector
    // for the whole APPLY/SETTLE/CHECK window.
    assign vec_out  = vec_idx;
    assign obs_t    = {tap_g, tap_f, tap_e};
    assign mismatch = (obs_t != exp_t);

    assign busy = (state == APPLY) || (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec_idx    <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
            fail_vec   <= '0;
            fail_taps  <= '0;
            fail_valid <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= APPLY;
                        vec_idx   <= '0;
                        err_count <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
                        fail_vec   <= '0;
                        fail_taps  <= '0;
                        fail_valid <= 1'b0;
`endif
                    end
                end
                APPLY: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
`ifdef FIRST_FAIL_CAPTURE_EN
                        if (!fail_valid) begin
                            fail_vec   <= vec_idx;
                            fail_taps  <= obs_t;
                            fail_valid <= 1'b1;
                        end
`endif
                    end
                    if (vec_idx == LAST_VEC) begin
                        state <= DONE;
                    end else begin
                        vec_idx <= vec_idx + 4'd1;
                        state   <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_and_chain_tester.sv
// tb_and_chain_tester: directed bench for and_chain_tester.
// dut0 uses default parameters with a fault-injectable chain model;
// dut1 uses SETTLE_CYCLES=1 with a healthy chain.
module tb_and_chain_tester;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [3:0] vec0, vec1;
    logic       e0, f0, g0, e1, f1, g1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [4:0] err0, err1;
    int         fault;   // 0 healthy, 1 tap_g stuck-at-1, 2 tap_e stuck-at-0
    int         n_vec  = 0;
    int         n_fail = 0;
    int         cyc;
`ifdef FIRST_FAIL_CAPTURE_EN
    logic [3:0] fvec0, fvec1;
    logic [2:0] ftaps0, ftaps1;
    logic       fvalid0, fvalid1;
`endif

    always #5 clk = ~clk;

    // chain under test for dut0, faults propagate downstream
    assign e0 = (fault == 2) ? 1'b0 : (vec0[0] & vec0[1]);
    assign f0 = e0 & vec0[2];
    assign g0 = (fault == 1) ? 1'b1 : (f0 & vec0[3]);

    assign e1 = vec1[0] & vec1[1];
    assign f1 = e1 & vec1[2];
    assign g1 = f1 & vec1[3];

    and_chain_tester #(.SETTLE_CYCLES(2), .CNT_W(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .vec_out(vec0),
        .tap_e(e0), .tap_f(f0), .tap_g(g0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef FIRST_FAIL_CAPTURE_EN
        , .fail_vec(fvec0), .fail_taps(ftaps0), .fail_valid(fvalid0)
`endif
    );

    and_chain_tester #(.SETTLE_CYCLES(1), .CNT_W(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .vec_out(vec1),
        .tap_e(e1), .tap_f(f1), .tap_g(g1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef FIRST_FAIL_CAPTURE_EN
        , .fail_vec(fvec1), .fail_taps(ftaps1), .fail_valid(fvalid1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue start, verify the accept edge, then count edges until done.
    task automatic run(input int which, input bit hold, input bit chk_vec, output int cycles);
        int s;
        s = (which != 0) ? 1 : 2;
        @(negedge clk);
        if (which != 0) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            start0 = 1'b0;
            start1 = 1'b0;
        end
        check("accept_busy", (which != 0) ? busy1 : busy0, 1);
        check("accept_done", (which != 0) ? done1 : done0, 0);
        check("accept_err",  (which != 0) ? err1  : err0,  0);
        check("accept_vec",  (which != 0) ? vec1  : vec0,  0);
`ifdef FIRST_FAIL_CAPTURE_EN
        check("accept_fvalid", (which != 0) ? fvalid1 : fvalid0, 0);
`endif
        cycles = 0;
        while (cycles < 300) begin
            @(posedge clk);
            cycles++;
            #1;
            if (((which != 0) ? done1 : done0) === 1'b1) break;
            if (chk_vec) check("vec_step", (which != 0) ? vec1 : vec0, cycles / (s + 2));
        end
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        fault  = 0;
        #2;
        check("rst_vec",  vec0,  0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err",  err0,  0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy0, 0);

        // healthy chain, single pulse
        run(0, 1'b0, 1'b1, cyc);
        check("healthy_cycles", cyc, 64);
        check("healthy_pass", pass0, 1);
        check("healthy_err",  err0,  0);
        check("healthy_busy", busy0, 0);
        check("healthy_vec",  vec0,  4'hF);
        repeat (5) @(posedge clk);
        #1;
        check("done_hold", done0, 1);
        check("done_vec_hold", vec0, 4'hF);

        // tap_g stuck-at-1: vectors 0..14 mismatch
        fault = 1;
        run(0, 1'b0, 1'b0, cyc);
        check("g_cycles", cyc, 64);
        check("g_err",  err0,  15);
        check("g_pass", pass0, 0);
`ifdef FIRST_FAIL_CAPTURE_EN
        check("g_fvalid", fvalid0, 1);
        check("g_fvec",   fvec0,   0);
        check("g_ftaps",  ftaps0,  3'b100);
`endif

        // tap_e stuck-at-0: vectors 3,7,11,15 mismatch; accept clears err 15
        fault = 2;
        run(0, 1'b0, 1'b0, cyc);
        check("e_cycles", cyc, 64);
        check("e_err",  err0,  4);
        check("e_pass", pass0, 0);
`ifdef FIRST_FAIL_CAPTURE_EN
        check("e_fvalid", fvalid0, 1);
        check("e_fvec",   fvec0,   3);
        check("e_ftaps",  ftaps0,  3'b000);
`endif

        // start held as a level across the whole run
        fault = 0;
        run(0, 1'b1, 1'b1, cyc);
        check("held_cycles", cyc, 64);
        check("held_err",  err0,  0);
        check("held_pass", pass0, 1);

        // reset mid-run at cycle 30 with a faulty chain
        fault = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mid_err_before_rst", err0, 7);
        check("mid_vec_before_rst", vec0, 7);
        rst_n = 1'b0;
        #1;
        check("async_vec",  vec0,  0);
        check("async_busy", busy0, 0);
        check("async_done", done0, 0);
        check("async_pass", pass0, 0);
        check("async_err",  err0,  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fault = 0;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_busy", busy0, 0);
        check("post_rst_done", done0, 0);
        check("post_rst_vec",  vec0,  0);

        // SETTLE_CYCLES=1 instance
        run(1, 1'b0, 1'b1, cyc);
        check("s1_cycles", cyc, 48);
        check("s1_pass", pass1, 1);
        check("s1_err",  err1,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
